// File: rtl/btn_cond_pkg.sv
// Shared constants and types for the pushbutton conditioning path:
// button indices, default board timing and the hold-to-repeat state encoding.
package btn_cond_pkg;

  localparam int BTN_CENTER = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_RIGHT  = 4;

  // Defaults assume a 50 MHz clock: 20 ms debounce, 0.5 s first repeat, 0.1 s repeat rate.
  localparam int DEF_NUM_BTN         = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_PERIOD   = 5_000_000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchronizer, stable-count debouncer, press edge detector
// and optional hold-to-repeat generator producing one-cycle strobes.
module button_channel
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HCNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] DELAY_LAST  = HCNT_W'(REPEAT_DELAY - 1);
  localparam logic [HCNT_W-1:0] PERIOD_LAST = HCNT_W'(REPEAT_PERIOD - 1);

  logic              s1;
  logic              s2;
  logic [CNT_W-1:0]  cnt;
  logic              rise;
  rep_state_t        state;
  rep_state_t        state_next;
  logic [HCNT_W-1:0] hcnt;
  logic [HCNT_W-1:0] hcnt_next;
  logic              pulse_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // True in the cycle whose closing edge flips level from 0 to 1.
  assign rise = s2 && !level && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hcnt  <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_next;
      hcnt  <= hcnt_next;
      pulse <= pulse_next;
    end
  end

  always_comb begin
    state_next = state;
    hcnt_next  = hcnt;
    case (state)
      IDLE: begin
        hcnt_next = '0;
        if (rise && REPEAT_EN) state_next = HOLD;
      end
      HOLD, REPEAT: begin
        // A release always wins over a repeat due in the same cycle.
        if (!level) begin
          hcnt_next  = '0;
          state_next = (rise && REPEAT_EN) ? HOLD : IDLE;
        end else if ((state == HOLD) ? (hcnt == DELAY_LAST) : (hcnt == PERIOD_LAST)) begin
          hcnt_next  = '0;
          state_next = REPEAT;
        end else begin
          hcnt_next = hcnt + HCNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        hcnt_next  = '0;
      end
    endcase
  end

  always_comb begin
    pulse_next = 1'b0;
    case (state)
      IDLE:    pulse_next = rise;
      HOLD:    pulse_next = level ? (hcnt == DELAY_LAST) : rise;
      REPEAT:  pulse_next = level ? (hcnt == PERIOD_LAST) : rise;
      default: pulse_next = 1'b0;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Board pushbuttons to game strobes: NUM_BTN independent conditioning channels
// producing one-cycle press/repeat pulses and debounced levels.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int                 NUM_BTN         = DEF_NUM_BTN,
  parameter int                 DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int                 REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int                 REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_level
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("button_conditioner: REPEAT_DELAY must be at least 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("button_conditioner: REPEAT_PERIOD must be at least 1");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[i]),
      .pulse(btn_pulse[i]),
      .level(btn_level[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing constants: press,
// bounce, hold-to-repeat, simultaneous press, glitch rejection and reset.
module tb_button_conditioner;
  import btn_cond_pkg::*;

  localparam int NB  = 5;
  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 3;
  localparam logic [NB-1:0] MASK = 5'b00010;
  localparam int REL_K = 30;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] seen;
  logic [NB-1:0] lseen;
  logic [NB-1:0] exp_v;
  int            total;
  int            bad;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      tick();
      seen  = seen | btn_pulse;
      lseen = lseen | btn_level;
    end
  endtask

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    btn_raw = '0;
    seen    = '0;
    lseen   = '0;
    exp_v   = '0;

    repeat (3) tick();
    check("reset_pulse", btn_pulse, 5'b00000);
    check("reset_level", btn_level, 5'b00000);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_pulse", btn_pulse, 5'b00000);

    // Clean press on center: level and pulse appear after edge DEB+2.
    btn_raw[BTN_CENTER] = 1'b1;
    seen = '0;
    watch(5);
    check("press_quiet", seen, 5'b00000);
    check("press_level_early", btn_level, 5'b00000);
    tick();
    check("press_pulse", btn_pulse, 5'b00001);
    check("press_level", btn_level, 5'b00001);
    tick();
    check("press_pulse_drop", btn_pulse, 5'b00000);
    seen = '0;
    watch(13);
    check("press_hold_quiet", seen, 5'b00000);
    btn_raw[BTN_CENTER] = 1'b0;
    seen = '0;
    watch(5);
    check("release_level_early", btn_level, 5'b00001);
    watch(1);
    check("release_level", btn_level, 5'b00000);
    watch(3);
    check("release_no_pulse", seen, 5'b00000);

    // Bounce on down: 1,0,1,0 for three cycles each, then steady high.
    seen = '0;
    for (int b = 0; b < 4; b++) begin
      btn_raw[BTN_DOWN] = (b % 2 == 0);
      watch(3);
    end
    btn_raw[BTN_DOWN] = 1'b1;
    watch(5);
    check("bounce_quiet", seen, 5'b00000);
    check("bounce_level_early", btn_level, 5'b00000);
    tick();
    check("bounce_pulse", btn_pulse, 5'b00100);
    tick();
    check("bounce_pulse_drop", btn_pulse, 5'b00000);
    btn_raw = '0;
    repeat (8) tick();
    check("bounce_released", btn_level, 5'b00000);

    // Hold-to-repeat on up; released in cycle P+REL_K, level last high at P+REL_K+DEB+1.
    btn_raw[BTN_UP] = 1'b1;
    repeat (DEB + 2) tick();
    check("rep_press", btn_pulse, 5'b00010);
    for (int k = 1; k <= 45; k++) begin
      tick();
      exp_v = (k >= DLY && k <= REL_K + DEB + 1 && (k - DLY) % PER == 0) ? 5'b00010 : 5'b00000;
      check($sformatf("rep_k%0d", k), btn_pulse, exp_v);
      if (k == REL_K + DEB + 1) check("rep_level_last", btn_level, 5'b00010);
      if (k == REL_K + DEB + 2) check("rep_level_fall", btn_level, 5'b00000);
      if (k == REL_K) btn_raw[BTN_UP] = 1'b0;
    end

    // Simultaneous press on three channels.
    btn_raw = 5'b11001;
    repeat (DEB + 1) tick();
    check("sim_early", btn_pulse, 5'b00000);
    tick();
    check("sim_pulse", btn_pulse, 5'b11001);
    check("sim_level", btn_level, 5'b11001);
    tick();
    check("sim_pulse_drop", btn_pulse, 5'b00000);
    btn_raw = '0;
    repeat (8) tick();
    check("sim_released", btn_level, 5'b00000);

    // Glitch on left: DEB consecutive high samples are accepted, so the longest
    // rejected glitch is one sample shorter.
    btn_raw[BTN_LEFT] = 1'b1;
    seen  = '0;
    lseen = '0;
    watch(DEB - 1);
    btn_raw[BTN_LEFT] = 1'b0;
    watch(10);
    check("glitch_pulse", seen, 5'b00000);
    check("glitch_level", lseen, 5'b00000);

    // Reset while up is repeating and center is mid-debounce.
    btn_raw[BTN_UP] = 1'b1;
    repeat (DEB + 2) tick();
    check("rst_pre_press", btn_pulse, 5'b00010);
    repeat (12) tick();
    btn_raw[BTN_CENTER] = 1'b1;
    repeat (2) tick();
    check("rst_pre_level", btn_level, 5'b00010);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_pulse", btn_pulse, 5'b00000);
    check("rst_async_level", btn_level, 5'b00000);
    repeat (3) tick();
    check("rst_held_level", btn_level, 5'b00000);
    rst_n = 1'b1;
    seen = '0;
    watch(DEB + 1);
    check("rst_rel_quiet", seen, 5'b00000);
    tick();
    check("rst_rel_pulse", btn_pulse, 5'b00011);
    check("rst_rel_level", btn_level, 5'b00011);
    seen = '0;
    watch(DLY - 1);
    check("rst_rel_single", seen, 5'b00000);
    tick();
    check("rst_rel_repeat", btn_pulse, 5'b00010);
    btn_raw = '0;
    repeat (8) tick();
    check("final_level", btn_level, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
